// File: rtl/lcd_uart_pkg.sv
// Shared types, defaults and helpers for the LCD-side UART transmitter.
package lcd_uart_pkg;

    localparam int DEFAULT_BAUD_DIV   = 1042;
    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int MAX_DATA_BITS      = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Zero-extended inputs leave the XOR unchanged, so narrower words can be passed in widened.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/lcd_uart_fifo.sv
// Single-clock FIFO with registered count/full/empty and show-ahead read data.
module lcd_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       SYSCLK,
    input  logic                       NSYSRESET,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;
    logic [AW:0]      count_nxt;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this edge; full/empty are registered from it.
    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) count_nxt = count + 1'b1;
        else if (do_rd && !do_wr) count_nxt = count - 1'b1;
    end

    // Storage array: no reset needed, contents are only visible through valid pointers.
    always_ff @(posedge SYSCLK) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers and status flags.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/lcd_uart_tx.sv
// Buffered UART transmitter: FIFO front end, baud counter and frame FSM.
module lcd_uart_tx
    import lcd_uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                          SYSCLK,
    input  logic                          NSYSRESET,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          tx_enable,
    output logic                          TXD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    tx_state_t            state_q, state_nxt;
    logic [CW-1:0]        baud_q, baud_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [3:0]           bit_q, bit_nxt;
    logic                 stop_q, stop_nxt;
    logic                 par_q, par_nxt;
    logic                 txd_q, txd_nxt;
    logic                 busy_q, busy_nxt;
    logic                 overflow_q;
    logic                 pop;
    logic                 tick;
    logic                 can_load;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    lcd_uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SYSCLK    (SYSCLK),
        .NSYSRESET (NSYSRESET),
        .wr_en     (wr_valid),
        .wr_data   (wr_data),
        .rd_en     (pop),
        .rd_data   (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign overflow = overflow_q;
    assign TXD      = txd_q;
    assign busy     = busy_q;
    assign tick     = (baud_q == BAUD_LAST);
    assign can_load = tx_enable && !fifo_empty;

    // Next-state logic; a load from IDLE or the final stop bit shares one path.
    always_comb begin
        state_nxt = state_q;
        baud_nxt  = tick ? '0 : baud_q + CW'(1);
        shift_nxt = shift_q;
        bit_nxt   = bit_q;
        stop_nxt  = stop_q;
        par_nxt   = par_q;
        txd_nxt   = txd_q;
        busy_nxt  = busy_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                baud_nxt = '0;
                txd_nxt  = 1'b1;
                busy_nxt = 1'b0;
                if (can_load) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_rd_data;
                    par_nxt   = calc_parity(MAX_DATA_BITS'(fifo_rd_data), PARITY_ODD != 0);
                    state_nxt = START;
                    txd_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    txd_nxt   = shift_q[0];
                    shift_nxt = shift_q >> 1;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        stop_nxt = 1'b0;
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            txd_nxt   = par_q;
                        end else begin
                            state_nxt = STOP;
                            txd_nxt   = 1'b1;
                        end
                    end else begin
                        txd_nxt   = shift_q[0];
                        shift_nxt = shift_q >> 1;
                        bit_nxt   = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    txd_nxt   = 1'b1;
                    stop_nxt  = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        if (can_load) begin
                            pop       = 1'b1;
                            shift_nxt = fifo_rd_data;
                            par_nxt   = calc_parity(MAX_DATA_BITS'(fifo_rd_data), PARITY_ODD != 0);
                            state_nxt = START;
                            txd_nxt   = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                            txd_nxt   = 1'b1;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            baud_q     <= baud_nxt;
            shift_q    <= shift_nxt;
            bit_q      <= bit_nxt;
            stop_q     <= stop_nxt;
            par_q      <= par_nxt;
            txd_q      <= txd_nxt;
            busy_q     <= busy_nxt;
            overflow_q <= wr_valid && fifo_full;
        end
    end

endmodule

// File: tb/tb_lcd_uart_tx.sv
// Directed bench: four transmitter configurations at BAUD_DIV=4 share one clock and reset.
module tb_lcd_uart_tx;

    logic SYSCLK = 1'b0;
    logic NSYSRESET;

    logic [7:0] wd0;  logic wv0, te0, wr0, t0, b0, ov0;  logic [4:0] fc0;
    logic [7:0] wdp;  logic wvp, tep;
    logic wr1, t1, b1, ov1;  logic [4:0] fc1;
    logic wr2, t2, b2, ov2;  logic [4:0] fc2;
    logic [4:0] wd3;  logic wv3, te3, wr3, t3, b3, ov3;  logic [4:0] fc3;

    int checks   = 0;
    int failures = 0;

    always #5 SYSCLK = ~SYSCLK;

    lcd_uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .wr_data(wd0), .wr_valid(wv0), .wr_ready(wr0),
        .tx_enable(te0), .TXD(t0), .busy(b0), .fifo_count(fc0), .overflow(ov0));

    lcd_uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .wr_data(wdp), .wr_valid(wvp), .wr_ready(wr1),
        .tx_enable(tep), .TXD(t1), .busy(b1), .fifo_count(fc1), .overflow(ov1));

    lcd_uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .wr_data(wdp), .wr_valid(wvp), .wr_ready(wr2),
        .tx_enable(tep), .TXD(t2), .busy(b2), .fifo_count(fc2), .overflow(ov2));

    lcd_uart_tx #(.BAUD_DIV(4), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_5n2 (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .wr_data(wd3), .wr_valid(wv3), .wr_ready(wr3),
        .tx_enable(te3), .TXD(t3), .busy(b3), .fifo_count(fc3), .overflow(ov3));

    function automatic logic txd_of(input int idx);
        case (idx)
            0: return t0;
            1: return t1;
            2: return t2;
            default: return t3;
        endcase
    endfunction

    function automatic logic busy_of(input int idx);
        case (idx)
            0: return b0;
            1: return b1;
            2: return b2;
            default: return b3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is just past the edge that starts the frame; bits[0] is the start bit.
    task automatic check_frame(input int idx, input logic [15:0] bits, input int nbits, input string tag);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge SYSCLK);
                check(tag, 32'(txd_of(idx)), 32'(bits[b]));
            end
        end
    endtask

    task automatic wait_idle(input int idx, input int limit);
        int n = 0;
        while (busy_of(idx) && n < limit) begin
            @(negedge SYSCLK);
            n++;
        end
        check("idle_timeout", 32'(busy_of(idx)), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fb;
        NSYSRESET = 1'b0;
        wd0 = '0; wv0 = 0; te0 = 0;
        wdp = '0; wvp = 0; tep = 0;
        wd3 = '0; wv3 = 0; te3 = 0;

        // Reset values
        #12;
        check("rst_txd",  32'(t0),  32'd1);
        check("rst_rdy",  32'(wr0), 32'd1);
        check("rst_busy", 32'(b0),  32'd0);
        check("rst_cnt",  32'(fc0), 32'd0);
        check("rst_ovf",  32'(ov0), 32'd0);
        check("rst_txd3", 32'(t3),  32'd1);
        @(negedge SYSCLK);
        NSYSRESET = 1'b1;
        repeat (2) @(negedge SYSCLK);

        // 8N1, 0x55: one idle cycle of latency, then the frame
        te0 = 1; wd0 = 8'h55; wv0 = 1;
        @(posedge SYSCLK); #1 wv0 = 0;
        @(negedge SYSCLK);
        check("lat_txd", 32'(t0),  32'd1);
        check("lat_cnt", 32'(fc0), 32'd1);
        @(posedge SYSCLK); #1;
        check("start_busy", 32'(b0), 32'd1);
        check_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, "frame_55");
        @(negedge SYSCLK);
        check("end55_busy", 32'(b0), 32'd0);
        check("end55_txd",  32'(t0), 32'd1);

        // Parity 0x07: even parity bit 1, odd parity bit 0, 44-cycle frame
        for (int p = 0; p < 2; p++) begin
            @(negedge SYSCLK);
            tep = 1; wdp = 8'h07; wvp = 1;
            @(posedge SYSCLK); #1 wvp = 0;
            @(posedge SYSCLK); #1;
            fb = (p == 0) ? {5'b0, 1'b1, 1'b1, 8'h07, 1'b0} : {5'b0, 1'b1, 1'b0, 8'h07, 1'b0};
            check_frame(1 + p, fb, 11, (p == 0) ? "frame_even" : "frame_odd");
            @(negedge SYSCLK);
            check("par_busy", 32'(busy_of(1 + p)), 32'd0);
        end

        // Fill FIFO with transmit disabled, then overflow
        @(negedge SYSCLK);
        te0 = 0; wv0 = 1;
        for (int i = 0; i < 16; i++) begin
            wd0 = 8'(i);
            @(posedge SYSCLK); #1;
        end
        wv0 = 0;
        @(negedge SYSCLK);
        check("full_cnt",  32'(fc0), 32'd16);
        check("full_rdy",  32'(wr0), 32'd0);
        check("full_busy", 32'(b0),  32'd0);
        check("full_ovf0", 32'(ov0), 32'd0);
        wv0 = 1; wd0 = 8'hAA;
        @(posedge SYSCLK); #1 wv0 = 0;
        @(negedge SYSCLK);
        check("ovf_pulse", 32'(ov0), 32'd1);
        check("ovf_cnt",   32'(fc0), 32'd16);
        @(negedge SYSCLK);
        check("ovf_clear", 32'(ov0), 32'd0);

        // Drain: 16 back-to-back frames 0x00..0x0F, no idle cycle
        te0 = 1;
        @(posedge SYSCLK); #1;
        check("pop_rdy", 32'(wr0), 32'd1);
        check("pop_cnt", 32'(fc0), 32'd15);
        for (int k = 0; k < 16; k++) begin
            fb = {6'b0, 1'b1, 8'(k), 1'b0};
            check_frame(0, fb, 10, "fifo_frame");
        end
        @(negedge SYSCLK);
        check("drain_busy", 32'(b0),  32'd0);
        check("drain_cnt",  32'(fc0), 32'd0);

        // Write coinciding with pop at the end of a stop bit
        te0 = 0; wv0 = 1;
        for (int i = 0; i < 4; i++) begin
            wd0 = 8'hA0 + 8'(i);
            @(posedge SYSCLK); #1;
        end
        wv0 = 0;
        @(negedge SYSCLK);
        te0 = 1;
        @(posedge SYSCLK); #1;
        check("sim_cnt_a", 32'(fc0), 32'd3);
        repeat (39) @(posedge SYSCLK);
        @(negedge SYSCLK);
        check("sim_stop_txd", 32'(t0),  32'd1);
        check("sim_cnt_b",    32'(fc0), 32'd3);
        wv0 = 1; wd0 = 8'hB0;
        @(posedge SYSCLK); #1 wv0 = 0;
        @(negedge SYSCLK);
        check("sim_cnt_c",  32'(fc0), 32'd3);
        check("sim_start",  32'(t0),  32'd0);
        check("sim_busy",   32'(b0),  32'd1);
        wait_idle(0, 300);
        check("sim_empty", 32'(fc0), 32'd0);

        // 5N2, 0x1B; tx_enable dropped mid-frame leaves 0x04 queued
        @(negedge SYSCLK);
        te3 = 1; wd3 = 5'h1B; wv3 = 1;
        @(posedge SYSCLK); #1 wd3 = 5'h04;
        @(posedge SYSCLK); #1 wv3 = 0; te3 = 0;
        check("q_cnt", 32'(fc3), 32'd1);
        check_frame(3, {8'b0, 2'b11, 5'h1B, 1'b0}, 8, "frame_1b");
        @(negedge SYSCLK);
        check("hold_busy", 32'(b3),  32'd0);
        check("hold_txd",  32'(t3),  32'd1);
        check("hold_cnt",  32'(fc3), 32'd1);
        repeat (10) @(negedge SYSCLK);
        check("hold2_txd",  32'(t3), 32'd1);
        check("hold2_busy", 32'(b3), 32'd0);
        te3 = 1;
        @(posedge SYSCLK); #1;
        check_frame(3, {8'b0, 2'b11, 5'h04, 1'b0}, 8, "frame_04");
        @(negedge SYSCLK);
        check("end04_busy", 32'(b3),  32'd0);
        check("end04_cnt",  32'(fc3), 32'd0);

        // Reset mid DATA bit 3 aborts immediately and discards the FIFO
        @(negedge SYSCLK);
        te0 = 1; wd0 = 8'h55; wv0 = 1;
        @(posedge SYSCLK); #1 wd0 = 8'h66;
        @(posedge SYSCLK); #1 wv0 = 0;
        repeat (17) @(posedge SYSCLK);
        #2;
        check("bit3_txd", 32'(t0),  32'd0);
        check("bit3_cnt", 32'(fc0), 32'd1);
        NSYSRESET = 1'b0;
        #1;
        check("arst_txd",  32'(t0),  32'd1);
        check("arst_cnt",  32'(fc0), 32'd0);
        check("arst_busy", 32'(b0),  32'd0);
        check("arst_rdy",  32'(wr0), 32'd1);
        @(negedge SYSCLK);
        NSYSRESET = 1'b1;
        repeat (2) @(negedge SYSCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
